// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-client round-robin arbiter with a registered one-hot grant,
// its binary index, and an optional hold limit that forces rotation when other
// clients are waiting.
//
// Optional feature macro: RR_ARB_CNT_EN
//   defined   -> grant_cnt port present; counts every grant event (wraps).
//   undefined -> grant_cnt port and counter are absent.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no client granted; grant/grant_idx/grant_valid are all zero
// GRANT | grant_idx owns the resource; hold_cnt counts cycles held
module rr_arbiter8 #(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
  output logic [7:0]       grant,
  output logic [2:0]       grant_idx,
  output logic             grant_valid
`ifdef RR_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0] grant_cnt
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic              HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] MAX_HOLD_V   = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE     = HOLD_W'(1);

  state_t            state;
  logic [2:0]        ptr;
  logic [HOLD_W-1:0] hold_cnt;

  logic [7:0]        cand_mask;
  logic              win_found;
  logic [2:0]        win_idx;
  logic [2:0]        pos;

  logic              owner_req;
  logic              release_g;
  logic              at_limit;
  logic              preempt;
  logic              take;
  logic              go_idle;
  logic              hold_inc;

  // Rotating priority search starting at ptr. While a grant is held the
  // current owner is masked out, so a release or preempt always hands over to
  // a different client and a just-released bit can never win the same edge.
  always_comb begin
    cand_mask = (state == GRANT) ? (req & ~grant) : req;
    win_found = 1'b0;
    win_idx   = 3'd0;
    pos       = 3'd0;
    // Walk from the farthest offset down so the nearest set bit wins last.
    for (int i = 7; i >= 0; i--) begin
      pos = ptr + 3'(i);
      if (cand_mask[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  // Next-action decode: new grant event, return to idle, or keep holding.
  always_comb begin
    owner_req = req[grant_idx];
    release_g = (state == GRANT) && !owner_req;
    at_limit  = HOLD_LIMITED && (hold_cnt == MAX_HOLD_V);
    preempt   = (state == GRANT) && owner_req && at_limit && win_found;
    take      = ((state == IDLE) && win_found) ||
                (release_g && win_found) ||
                preempt;
    go_idle   = release_g && !win_found;
    hold_inc  = (state == GRANT) && HOLD_LIMITED && (hold_cnt != MAX_HOLD_V);
  end

  // Arbiter FSM with registered outputs; reset drops the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      ptr         <= 3'd0;
      hold_cnt    <= '0;
    end else if (take) begin
      state       <= GRANT;
      grant       <= 8'b1 << win_idx;
      grant_idx   <= win_idx;
      grant_valid <= 1'b1;
      ptr         <= win_idx + 3'd1;
      hold_cnt    <= HOLD_ONE;
    end else if (go_idle) begin
      state       <= IDLE;
      grant       <= 8'h00;
      grant_idx   <= 3'd0;
      grant_valid <= 1'b0;
      hold_cnt    <= '0;
    end else if (hold_inc) begin
      // Saturates at MAX_HOLD; with no limit the count is not needed.
      hold_cnt    <= hold_cnt + HOLD_ONE;
    end
  end

`ifdef RR_ARB_CNT_EN
  // Grant event counter, including preempts and no-bubble handovers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt <= '0;
    end else if (take) begin
      grant_cnt <= grant_cnt + CNT_W'(1);
    end
  end
`else
  // CNT_W only sizes the optional counter; keep it referenced in this build.
  if (CNT_W < 1) begin : g_no_cnt
  end
`endif

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed scoreboard bench for rr_arbiter8 (MAX_HOLD=4, CNT_W=2).
module tb_rr_arbiter8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
`ifdef RR_ARB_CNT_EN
  logic [1:0] grant_cnt;
`endif

  typedef struct {
    logic [7:0] g;
    logic [1:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  logic [7:0] model_prev;
  logic [1:0] model_cnt;

  rr_arbiter8 #(
    .MAX_HOLD(4),
    .HOLD_W  (4),
    .CNT_W   (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
`ifdef RR_ARB_CNT_EN
    ,
    .grant_cnt  (grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected grant event count: an event is any edge producing a new nonzero grant.
  task automatic push(input logic [7:0] g, input string tag);
    exp_t e;
    if (g != 8'h00 && g != model_prev) model_cnt = model_cnt + 2'd1;
    model_prev = g;
    e.g   = g;
    e.cnt = model_cnt;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_pop();
    exp_t       e;
    logic [2:0] ei;
    logic       ev;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty got=0 entries exp=1");
    end
    if (sb.size() != 0) begin
      e  = sb.pop_front();
      ei = 3'd0;
      for (int i = 0; i < 8; i++) if (e.g[i]) ei = 3'(i);
      ev = (e.g != 8'h00);
      checks++;
      assert (grant === e.g) else begin
        failures++;
        $error("FAIL %s grant got=%h exp=%h", e.tag, grant, e.g);
      end
      checks++;
      assert (grant_idx === ei) else begin
        failures++;
        $error("FAIL %s grant_idx got=%0d exp=%0d", e.tag, grant_idx, ei);
      end
      checks++;
      assert (grant_valid === ev) else begin
        failures++;
        $error("FAIL %s grant_valid got=%b exp=%b", e.tag, grant_valid, ev);
      end
`ifdef RR_ARB_CNT_EN
      checks++;
      assert (grant_cnt === e.cnt) else begin
        failures++;
        $error("FAIL %s grant_cnt got=%0d exp=%0d", e.tag, grant_cnt, e.cnt);
      end
`endif
    end
  endtask

  // Drive req, let one edge sample it, then check just after the edge.
  task automatic step(input logic [7:0] r, input logic [7:0] g, input string tag);
    req = r;
    push(g, tag);
    @(posedge clk);
    #1;
    check_pop();
  endtask

  initial begin
    rst        = 1'b1;
    req        = 8'hFF;
    model_prev = 8'h00;
    model_cnt  = 2'd0;

    // Reset holds outputs low even with all requests and clock edges.
    @(posedge clk);
    @(posedge clk);
    #1;
    push(8'h00, "reset_hold");
    check_pop();

    // Release reset between edges; first edge grants client 0.
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    push(8'h01, "first_grant");
    check_pop();

    // All requesting: each client holds exactly 4 cycles, then rotation wraps.
    for (int c = 1; c < 4; c++) step(8'hFF, 8'h01, "rr_hold_c0");
    for (int k = 1; k <= 8; k++)
      for (int c = 0; c < 4; c++)
        step(8'hFF, 8'h01 << (k % 8), "rr_rotate");

    // Lone requester: handover without bubble, then never preempted.
    for (int c = 0; c < 20; c++) step(8'h10, 8'h10, "lone_hold");

    // Release of bit 4 with bits 0,2 pending: search from 5 wraps to 0.
    step(8'h05, 8'h01, "wrap_to_0");
    step(8'h04, 8'h04, "no_bubble");
    step(8'h00, 8'h00, "to_idle");
    step(8'h00, 8'h00, "stay_idle");

    // ptr is 3 after client 2; from idle, search 3..7 wraps to client 0.
    step(8'h03, 8'h01, "idle_wrap");

    // Two-client preempt: owner 0 at limit hands to 1, then back.
    for (int c = 1; c < 4; c++) step(8'h03, 8'h01, "pair_hold0");
    for (int c = 0; c < 4; c++) step(8'h03, 8'h02, "pair_hold1");
    step(8'h03, 8'h01, "pair_back");

    // Asynchronous reset mid-grant, between clock edges.
    #2 rst = 1'b1;
    #1;
    model_prev = 8'h00;
    model_cnt  = 2'd0;
    push(8'h00, "async_reset");
    check_pop();
    #1 rst = 1'b0;

    // ptr restarted at 0: with 0 and 7 requesting, client 0 wins.
    step(8'h81, 8'h01, "ptr_reset");
    step(8'h80, 8'h80, "client7");
    step(8'h00, 8'h00, "final_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
